// File: rtl/rm_lane_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rm_lane_sequencer_if
// Brief    : Bundles the per-lane event/reset inputs, the configuration write
//            port and the match/step outputs of the RM lane sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface rm_lane_sequencer_if #(
  parameter int NUM_LANES  = 5,
  parameter int NUM_EVENTS = 10,
  parameter int MAX_STEPS  = 4,
  parameter int WIN_W      = 8,
  parameter int CNT_W      = 16
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int LEN_W  = $clog2(MAX_STEPS + 1);

  logic [NUM_LANES-1:0][NUM_EVENTS-1:0] lane_vector_i;
  logic [NUM_LANES-1:0]                 lane_reset_i;
  logic                                 cfg_we_i;
  logic [LANE_W-1:0]                    cfg_lane_i;
  logic [STEP_W-1:0]                    cfg_step_i;
  logic [NUM_EVENTS-1:0]                cfg_mask_i;
  logic [LEN_W-1:0]                     cfg_len_i;
  logic [WIN_W-1:0]                     cfg_window_i;
  logic [NUM_LANES-1:0]                 match_o;
  logic [NUM_LANES-1:0][CNT_W-1:0]      match_cnt_o;
  logic [NUM_LANES-1:0][STEP_W-1:0]     step_o;

  modport master (
    output lane_vector_i, lane_reset_i, cfg_we_i, cfg_lane_i, cfg_step_i,
           cfg_mask_i, cfg_len_i, cfg_window_i,
    input  match_o, match_cnt_o, step_o
  );

  modport slave (
    input  lane_vector_i, lane_reset_i, cfg_we_i, cfg_lane_i, cfg_step_i,
           cfg_mask_i, cfg_len_i, cfg_window_i,
    output match_o, match_cnt_o, step_o
  );
endinterface
`default_nettype wire

// File: rtl/rm_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rm_lane_sequencer
// Brief    : Per-lane ordered-sequence matcher. Each lane walks through up to
//            MAX_STEPS event masks with an optional inter-step timeout and
//            pulses match / bumps a saturating counter on completion.
// Revision : 1.0  initial release
// ============================================================================
module rm_lane_sequencer #(
  parameter int NUM_LANES  = 5,
  parameter int NUM_EVENTS = 10,
  parameter int MAX_STEPS  = 4,
  parameter int WIN_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rm_lane_sequencer_if.slave  bus
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int LEN_W  = $clog2(MAX_STEPS + 1);

  // Shared config decode: a write is dropped entirely if lane or step is out
  // of range, and an oversize length is clamped before it is stored.
  logic             w_cfg_ok;
  logic [LEN_W-1:0] w_len_clamped;

  assign w_cfg_ok = bus.cfg_we_i
                 && ({1'b0, bus.cfg_lane_i} < (LANE_W+1)'(NUM_LANES))
                 && ({1'b0, bus.cfg_step_i} < (STEP_W+1)'(MAX_STEPS));

  assign w_len_clamped = (bus.cfg_len_i > LEN_W'(MAX_STEPS)) ? LEN_W'(MAX_STEPS)
                                                             : bus.cfg_len_i;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [NUM_EVENTS-1:0] r_mask [MAX_STEPS];
    logic [LEN_W-1:0]      r_len;
    logic [WIN_W-1:0]      r_cfg_win;
    logic [STEP_W-1:0]     r_step;
    logic [WIN_W-1:0]      r_win;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_match;

    logic                  w_cfg_sel;
    logic                  w_hit;
    logic                  w_last;
    logic [LEN_W-1:0]      w_step_ext;

    assign w_cfg_sel  = w_cfg_ok && (bus.cfg_lane_i == LANE_W'(l));
    // A lane with length 0 is disabled, so it can never register a hit.
    assign w_hit      = (r_len != '0) && ((bus.lane_vector_i[l] & r_mask[r_step]) != '0);
    assign w_step_ext = LEN_W'(r_step);
    assign w_last     = ((w_step_ext + LEN_W'(1)) == r_len);

    // Configuration storage and the per-lane sequencing state, in priority
    // order: lane reset, config write, final hit, intermediate hit, timeout.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < MAX_STEPS; s++) begin
          r_mask[s] <= '0;
        end
        r_len     <= '0;
        r_cfg_win <= '0;
        r_step    <= '0;
        r_win     <= '0;
        r_cnt     <= '0;
        r_match   <= 1'b0;
      end else begin
        r_match <= 1'b0;

        if (w_cfg_sel) begin
          r_mask[bus.cfg_step_i] <= bus.cfg_mask_i;
          r_len                  <= w_len_clamped;
          r_cfg_win              <= bus.cfg_window_i;
        end

        if (bus.lane_reset_i[l]) begin
          r_step <= '0;
          r_win  <= '0;
          r_cnt  <= '0;
        end else if (w_cfg_sel) begin
          // Reconfiguration restarts the sequence but keeps the match history.
          r_step <= '0;
          r_win  <= '0;
        end else if (w_hit && w_last) begin
          r_step  <= '0;
          r_win   <= '0;
          r_match <= 1'b1;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (w_hit) begin
          r_step <= r_step + STEP_W'(1);
          r_win  <= r_cfg_win;
        end else if ((r_step != '0) && (r_cfg_win != '0)) begin
          // Timeout fires on the cycle the counter would otherwise reach 0.
          if (r_win <= WIN_W'(1)) begin
            r_step <= '0;
            r_win  <= '0;
          end else begin
            r_win <= r_win - WIN_W'(1);
          end
        end
      end
    end

    assign bus.match_o[l]     = r_match;
    assign bus.match_cnt_o[l] = r_cnt;
    assign bus.step_o[l]      = r_step;
  end

endmodule
`default_nettype wire

// File: tb/tb_rm_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rm_lane_sequencer
// Brief    : Directed scenarios followed by random traffic, every cycle
//            compared against a timestamp-based behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rm_lane_sequencer;
  localparam int NL = 5;
  localparam int NE = 10;
  localparam int MS = 4;
  localparam int WW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef logic [NL-1:0][NE-1:0] vec_t;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rm_lane_sequencer_if #(.NUM_LANES(NL), .NUM_EVENTS(NE), .MAX_STEPS(MS),
                         .WIN_W(WW), .CNT_W(CW)) bus ();

  rm_lane_sequencer #(.NUM_LANES(NL), .NUM_EVENTS(NE), .MAX_STEPS(MS),
                      .WIN_W(WW), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference model: a lane remembers the cycle it last advanced and times
  // out once the configured number of cycles has elapsed without a hit.
  logic [NE-1:0] m_mask [NL][MS];
  int            m_len   [NL];
  int            m_win   [NL];
  int            m_step  [NL];
  int            m_adv   [NL];
  int            m_cnt   [NL];
  bit            m_match [NL];
  int            cyc;

  int n_tests;
  int n_fail;

  vec_t v;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      for (int s = 0; s < MS; s++) m_mask[l][s] = '0;
      m_len[l] = 0; m_win[l] = 0; m_step[l] = 0;
      m_adv[l] = 0; m_cnt[l] = 0; m_match[l] = 1'b0;
    end
  endtask

  task automatic model_step(input vec_t vec, input logic [NL-1:0] rl, input logic we,
                            input int lane, input int stp, input logic [NE-1:0] mask,
                            input int len, input int win);
    bit cfg_ok;
    bit hit;
    cyc++;
    cfg_ok = we && (lane < NL) && (stp < MS);
    for (int l = 0; l < NL; l++) begin
      m_match[l] = 1'b0;
      hit = (m_len[l] != 0) && ((vec[l] & m_mask[l][m_step[l]]) != '0);
      if (rl[l]) begin
        m_step[l] = 0;
        m_cnt[l]  = 0;
      end else if (cfg_ok && lane == l) begin
        m_step[l] = 0;
      end else if (hit) begin
        if (m_step[l] == m_len[l] - 1) begin
          m_step[l]  = 0;
          m_match[l] = 1'b1;
          if (m_cnt[l] < CNT_MAX) m_cnt[l]++;
        end else begin
          m_step[l]++;
          m_adv[l] = cyc;
        end
      end else if (m_step[l] > 0 && m_win[l] != 0 && (cyc - m_adv[l]) >= m_win[l]) begin
        m_step[l] = 0;
      end
    end
    if (cfg_ok) begin
      m_mask[lane][stp] = mask;
      m_len[lane]       = (len > MS) ? MS : len;
      m_win[lane]       = win;
    end
  endtask

  task automatic compare_all();
    logic [NL-1:0] exp_m;
    for (int l = 0; l < NL; l++) exp_m[l] = m_match[l];
    check_value("match_o", 32'(bus.match_o), 32'(exp_m));
    for (int l = 0; l < NL; l++) begin
      check_value($sformatf("step_o[%0d]", l), 32'(bus.step_o[l]), m_step[l]);
      check_value($sformatf("match_cnt_o[%0d]", l), 32'(bus.match_cnt_o[l]), m_cnt[l]);
    end
  endtask

  task automatic drive(input vec_t vec, input logic [NL-1:0] rl, input logic we,
                       input int lane, input int stp, input logic [NE-1:0] mask,
                       input int len, input int win);
    bus.lane_vector_i = vec;
    bus.lane_reset_i  = rl;
    bus.cfg_we_i      = we;
    bus.cfg_lane_i    = 3'(lane);
    bus.cfg_step_i    = 2'(stp);
    bus.cfg_mask_i    = mask;
    bus.cfg_len_i     = 3'(len);
    bus.cfg_window_i  = WW'(win);
    @(posedge clk);
    model_step(vec, rl, we, lane, stp, mask, len, win);
    #1;
    compare_all();
  endtask

  task automatic tick(input vec_t vec, input logic [NL-1:0] rl);
    drive(vec, rl, 1'b0, 0, 0, '0, 0, 0);
  endtask

  task automatic cfg(input int lane, input int stp, input logic [NE-1:0] mask,
                     input int len, input int win, input vec_t vec);
    drive(vec, '0, 1'b1, lane, stp, mask, len, win);
  endtask

  function automatic vec_t one_lane(input int l, input logic [NE-1:0] val);
    vec_t r;
    r = '0;
    r[l] = val;
    return r;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    model_reset();
    bus.lane_vector_i = '0;
    bus.lane_reset_i  = '0;
    bus.cfg_we_i      = 1'b0;
    bus.cfg_lane_i    = '0;
    bus.cfg_step_i    = '0;
    bus.cfg_mask_i    = '0;
    bus.cfg_len_i     = '0;
    bus.cfg_window_i  = '0;

    // Global reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Basic match on lane 0
    cfg(0, 0, 10'h001, 2, 0, '0);
    cfg(0, 1, 10'h002, 2, 0, '0);
    tick(one_lane(0, 10'h001), '0);
    tick(one_lane(0, 10'h002), '0);
    check_value("basic_match", 32'(bus.match_o[0]), 1);
    check_value("basic_cnt", 32'(bus.match_cnt_o[0]), 1);

    // Timeout on lane 1 (window 3)
    cfg(1, 0, 10'h001, 2, 3, '0);
    cfg(1, 1, 10'h002, 2, 3, '0);
    tick(one_lane(1, 10'h001), '0);
    check_value("to_step1", 32'(bus.step_o[1]), 1);
    repeat (3) tick('0, '0);
    check_value("to_expired", 32'(bus.step_o[1]), 0);
    tick(one_lane(1, 10'h002), '0);
    check_value("to_nomatch", 32'(bus.match_o[1]), 0);
    tick(one_lane(1, 10'h001), '0);
    tick('0, '0);
    tick(one_lane(1, 10'h002), '0);
    check_value("to_inwindow", 32'(bus.match_o[1]), 1);

    // Reset priority on lane 2
    cfg(2, 0, 10'h001, 2, 0, '0);
    cfg(2, 1, 10'h002, 2, 0, '0);
    repeat (5) begin
      tick(one_lane(2, 10'h001), '0);
      tick(one_lane(2, 10'h002), '0);
    end
    tick(one_lane(2, 10'h001), '0);
    check_value("rp_cnt5", 32'(bus.match_cnt_o[2]), 5);
    tick(one_lane(2, 10'h002), 5'b00100);
    check_value("rp_nomatch", 32'(bus.match_o[2]), 0);
    check_value("rp_cnt0", 32'(bus.match_cnt_o[2]), 0);

    // Saturation and back-to-back on lane 3 (len 1)
    cfg(3, 0, 10'h001, 1, 0, '0);
    for (int i = 0; i < 20; i++) begin
      tick(one_lane(3, 10'h001), '0);
      check_value("sat_pulse", 32'(bus.match_o[3]), 1);
    end
    check_value("sat_cnt", 32'(bus.match_cnt_o[3]), 15);

    // Concurrent completion on lanes 0 and 4, lane 1 mid-sequence
    cfg(4, 0, 10'h001, 2, 0, '0);
    cfg(4, 1, 10'h002, 2, 0, '0);
    v = '0; v[0] = 10'h001; v[4] = 10'h001; v[1] = 10'h001;
    tick(v, '0);
    v = '0; v[0] = 10'h002; v[4] = 10'h002;
    tick(v, '0);
    check_value("conc_match", 32'(bus.match_o), 32'h11);
    check_value("conc_step1", 32'(bus.step_o[1]), 1);

    // Config write while lane 0 is at step 1 with a last-step hit present
    tick(one_lane(0, 10'h001), '0);
    cfg(0, 0, 10'h001, 2, 0, one_lane(0, 10'h002));
    check_value("cw_step", 32'(bus.step_o[0]), 0);
    check_value("cw_cnt", 32'(bus.match_cnt_o[0]), 2);
    check_value("cw_nomatch", 32'(bus.match_o[0]), 0);
    cfg(7, 0, 10'h3FF, 1, 5, '0);
    tick(one_lane(0, 10'h001), '0);
    tick(one_lane(0, 10'h002), '0);
    check_value("oor_ignored", 32'(bus.match_o[0]), 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [NL-1:0] rl;
      logic [NE-1:0] mk;
      for (int l = 0; l < NL; l++) begin
        v[l]  = NE'($urandom & $urandom);
        rl[l] = ($urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 9) == 0) begin
        mk = NE'(1) << $urandom_range(0, NE-1);
        if ($urandom_range(0, 3) == 0) mk = mk | (NE'(1) << $urandom_range(0, NE-1));
        drive(v, rl, 1'b1, $urandom_range(0, 7), $urandom_range(0, MS-1), mk,
              $urandom_range(0, 7), $urandom_range(0, 5));
      end else begin
        tick(v, rl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rm_lane_sequencer.md
Name: rm_lane_sequencer

Overview:
- Receive-side consumer of the routed per-lane event vectors and per-lane reset strobes produced by the RM event routing stage.
- Each lane runs an independent ordered-sequence matcher. A lane advances through up to MAX_STEPS configured event masks, with an optional inter-step timeout window.
- On completing its sequence, a lane pulses match and increments a saturating match counter. The RM monitor uses these outputs for reporting and response.

Parameters:
- NUM_LANES, 5, number of lanes; must match the router.
- NUM_EVENTS, 10, width of each lane's event vector.
- MAX_STEPS, 4, maximum sequence length per lane.
- WIN_W, 8, width of the per-lane timeout window counter.
- CNT_W, 16, width of the per-lane match counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- lane_vector_i  in  NUM_LANES x NUM_EVENTS  per-lane event hits for this cycle.
- lane_reset_i  in  NUM_LANES  per-lane reset strobe.
- cfg_we_i  in  1  config write strobe.
- cfg_lane_i  in  $clog2(NUM_LANES)  lane being configured.
- cfg_step_i  in  $clog2(MAX_STEPS)  step index whose mask is written.
- cfg_mask_i  in  NUM_EVENTS  event mask for that step.
- cfg_len_i  in  $clog2(MAX_STEPS+1)  sequence length for the lane; written together with the mask.
- cfg_window_i  in  WIN_W  timeout window for the lane; 0 disables the timeout.
- match_o  out  NUM_LANES  one-cycle pulse when a lane completes its sequence.
- match_cnt_o  out  NUM_LANES x CNT_W  saturating count of completed matches.
- step_o  out  NUM_LANES x $clog2(MAX_STEPS)  current step index per lane.

Behaviour:
- Reset (rst_i=1, synchronous):
  - All masks, lengths and windows are cleared to 0.
  - step_o=0, window counters=0, match_o=0, match_cnt_o=0.
- Lane disabled:
  - A lane is disabled while len==0 and never advances.
  - A len greater than MAX_STEPS is clamped to MAX_STEPS.
- Step hit:
  - A step is hit when (lane_vector_i[l] & mask[l][step]) != 0.
  - A lane advances by at most one step per cycle.
- Per-lane state transitions, evaluated each cycle in priority order:
  1. lane_reset_i[l]=1: step<=0, window<=0, match_cnt<=0, match_o[l]=0 next cycle. Any hit in the same cycle is ignored.
  2. Hit on the last step (step==len-1): step<=0, window<=0, match_o[l]<=1 on the next cycle, match_cnt<=match_cnt+1. The counter saturates at all-ones and never wraps. A len==1 sequence matches on every hit cycle, giving back-to-back pulses.
  3. Hit on a non-last step: step<=step+1, window<=cfg window.
  4. No hit, step>0, window config !=0: window<=window-1. When the window is 1 and no hit occurs, a timeout fires: step<=0, window<=0. The timeout takes effect on the cycle the counter would reach 0.
  5. Otherwise: hold.
- Timeout cycle: a step-0 hit in the timeout cycle is not re-evaluated. The lane returns to step 0 only; the next cycle's hit may advance it.
- Window config 0: no timeout; the lane waits indefinitely at step>0.
- Latency: match_o and match_cnt_o are registered, one cycle after the completing hit. step_o reflects registered state.
- Config write (cfg_we_i=1):
  - Takes effect on the next cycle.
  - Updates mask[cfg_lane_i][cfg_step_i], len[cfg_lane_i] and window[cfg_lane_i].
  - Forces that lane to step 0 with window 0. match_cnt is preserved.
  - The addressed lane does not advance in the write cycle. If lane_reset_i is also asserted for that lane, the counter is also cleared.
- Out-of-range writes: cfg_lane_i >= NUM_LANES or cfg_step_i >= MAX_STEPS are ignored entirely.
- Lane independence: lanes are fully independent; simultaneous matches on several lanes all pulse in the same cycle.

Test Plan:
- Basic match: lane 0 configured len=2, mask0=0x001, mask1=0x002, window=0. Drive lane0 vector 0x001 then 0x002 -> match_o[0]=1 one cycle after the second hit, match_cnt[0]=1, step_o[0]=0.
- Timeout: lane 1 configured len=2, window=3. Hit step 0, then idle 3 cycles -> step_o[1] returns to 0. A later 0x002 gives no match. Repeat with the step-1 hit on idle cycle 2 -> match.
- Reset priority: lane 2 at step 1 with match_cnt=5; assert lane_reset_i[2] together with a last-step hit -> no match pulse, match_cnt[2]=0, step_o[2]=0.
- Saturation and back-to-back: lane 3 configured len=1, CNT_W=4 build. Drive a hit for 20 consecutive cycles -> match_o[3] high 20 consecutive cycles, match_cnt[3] holds at 15.
- Concurrent lanes: lanes 0 and 4 complete in the same cycle while lane 1 is mid-sequence -> match_o=5'b10001, step_o[1] unaffected.
- Config write: configuration write to lane 0 while at step 1 with match_cnt=2 -> step 0, match_cnt still 2, and no advance in the write cycle. A write with cfg_lane_i=7 changes nothing.
